// File: rtl/demux4_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux4_stream
// Description : 1-to-4 valid/ready stream demultiplexer with a one-entry
//               register slice per output channel and an accepted-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
module demux4_stream #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in1,
    input  logic [1:0]           sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     ou1,
    output logic [WIDTH-1:0]     ou2,
    output logic [WIDTH-1:0]     ou3,
    output logic [WIDTH-1:0]     ou4,
    output logic [3:0]           ou_valid,
    input  logic [3:0]           ou_ready,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    logic                 w_accept;
    logic [WIDTH-1:0]     w_data [4];
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Readiness looks only at the selected slice, so a stalled channel
    // blocks the producer only while it is being addressed.
    assign in_ready = rst_n & (~ou_valid[sel] | ou_ready[sel]);
    assign w_accept = in_valid & in_ready;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_ch
            logic             valid_q;
            logic             valid_d;
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;

            // A load wins over a drain, which gives full-rate pass-through.
            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (w_accept && (sel == 2'(k))) begin
                    valid_d = 1'b1;
                    data_d  = in1;
                end else if (valid_q && ou_ready[k]) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign ou_valid[k] = valid_q;
            assign w_data[k]   = data_q;
        end
    endgenerate

    assign ou1 = w_data[0];
    assign ou2 = w_data[1];
    assign ou3 = w_data[2];
    assign ou4 = w_data[3];

    always_comb begin
        cnt_d = cnt_q;
        if (w_accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demux4_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux4_stream
// Description : Directed and randomized bench for demux4_stream against a
//               per-channel slot model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux4_stream;

    logic        clk;
    logic        rst_n;
    logic [31:0] in1;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ou1, ou2, ou3, ou4;
    logic [3:0]  ou_valid;
    logic [3:0]  ou_ready;
    logic [15:0] xfer_cnt;

    demux4_stream #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in1      (in1),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ou1      (ou1),
        .ou2      (ou2),
        .ou3      (ou3),
        .ou4      (ou4),
        .ou_valid (ou_valid),
        .ou_ready (ou_ready),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: each channel is a slot that is either empty or holds one word.
    bit        m_full [4];
    bit [31:0] m_data [4];
    bit [15:0] m_cnt;
    bit        last_exp_rdy;
    logic      last_dut_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = '0;
        end
        m_cnt = '0;
    endtask

    // One clock cycle: drive at the falling edge, check readiness, clock,
    // then compare every output against the model at the next falling edge.
    task automatic step(input bit rstn, input bit iv, input bit [31:0] d,
                        input bit [1:0] s, input bit [3:0] rdy);
        bit exp_rdy;
        bit acc;
        bit [3:0] exp_v;
        rst_n    = rstn;
        in_valid = iv;
        in1      = d;
        sel      = s;
        ou_ready = rdy;
        #1;
        exp_rdy      = rstn && (!m_full[s] || rdy[s]);
        last_exp_rdy = exp_rdy;
        last_dut_rdy = in_ready;
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        acc = iv && exp_rdy;
        @(posedge clk);
        if (!rstn) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m_full[k] && rdy[k]) m_full[k] = 1'b0;  // consumer takes the word
            end
            if (acc) begin
                m_full[s] = 1'b1;
                m_data[s] = d;
                m_cnt     = m_cnt + 16'd1;
            end
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) exp_v[k] = m_full[k];
        chk("ou_valid", {28'b0, ou_valid}, {28'b0, exp_v});
        chk("ou1", ou1, m_data[0]);
        chk("ou2", ou2, m_data[1]);
        chk("ou3", ou3, m_data[2]);
        chk("ou4", ou4, m_data[3]);
        chk("xfer_cnt", {16'b0, xfer_cnt}, {16'b0, m_cnt});
    endtask

    initial begin
        bit        hold;
        bit        riv;
        bit [31:0] rd;
        bit [1:0]  rs;
        bit [3:0]  rr;

        rst_n = 1'b0; in_valid = 1'b0; in1 = '0; sel = '0; ou_ready = '0;
        model_reset();
        @(negedge clk);

        // T1 reset with in_valid asserted
        step(1'b0, 1'b1, 32'hDEAD, 2'd1, 4'b1111);
        chk("t1_rdy0", {31'b0, last_dut_rdy}, 32'd0);
        step(1'b0, 1'b1, 32'hBEEF, 2'd2, 4'b1111);
        chk("t1_valid", {28'b0, ou_valid}, 32'd0);
        chk("t1_cnt", {16'b0, xfer_cnt}, 32'd0);
        chk("t1_ou4", ou4, 32'd0);

        // T2 routing back-to-back
        step(1'b1, 1'b1, 32'hA0, 2'd0, 4'b1111);
        chk("t2_v0", {28'b0, ou_valid}, 32'b0001);
        chk("t2_ou1", ou1, 32'hA0);
        step(1'b1, 1'b1, 32'hB1, 2'd1, 4'b1111);
        chk("t2_v1", {28'b0, ou_valid}, 32'b0010);
        step(1'b1, 1'b1, 32'hC2, 2'd2, 4'b1111);
        chk("t2_v2", {28'b0, ou_valid}, 32'b0100);
        step(1'b1, 1'b1, 32'hD3, 2'd3, 4'b1111);
        chk("t2_v3", {28'b0, ou_valid}, 32'b1000);
        chk("t2_ou4", ou4, 32'hD3);
        chk("t2_cnt", {16'b0, xfer_cnt}, 32'd4);
        step(1'b1, 1'b0, 32'h0, 2'd0, 4'b1111);

        // T3 stall on one channel, others keep flowing
        step(1'b1, 1'b1, 32'h11, 2'd2, 4'b0000);
        chk("t3_ou3", ou3, 32'h11);
        chk("t3_v", {28'b0, ou_valid}, 32'b0100);
        step(1'b1, 1'b1, 32'h22, 2'd2, 4'b0000);
        chk("t3_block", {31'b0, last_dut_rdy}, 32'd0);
        step(1'b1, 1'b1, 32'h33, 2'd0, 4'b0000);
        chk("t3_ou1", ou1, 32'h33);
        step(1'b1, 1'b1, 32'h22, 2'd2, 4'b0100);
        chk("t3_drain", {31'b0, last_dut_rdy}, 32'd1);
        chk("t3_ou3b", ou3, 32'h22);

        // T4 pass-through on a full channel
        step(1'b1, 1'b1, 32'h44, 2'd1, 4'b0000);
        step(1'b1, 1'b1, 32'h55, 2'd1, 4'b0010);
        chk("t4_rdy", {31'b0, last_dut_rdy}, 32'd1);
        chk("t4_ou2", ou2, 32'h55);
        chk("t4_v1", {31'b0, ou_valid[1]}, 32'd1);

        // Randomized traffic; the producer holds a refused word
        hold = 1'b0; riv = 1'b0; rd = '0; rs = '0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                riv = ($urandom_range(0, 3) != 0);
                rd  = $urandom;
                rs  = 2'($urandom_range(0, 3));
            end
            rr = 4'($urandom);
            step(1'b1, riv, rd, rs, rr);
            hold = riv && !last_exp_rdy;
        end

        // T5 counter wrap
        step(1'b0, 1'b0, 32'h0, 2'd0, 4'b1111);
        for (int i = 0; i < 16'hFFFE; i++) begin
            step(1'b1, 1'b1, 32'(i), 2'(i), 4'b1111);
        end
        chk("t5_fffe", {16'b0, xfer_cnt}, 32'hFFFE);
        step(1'b1, 1'b1, 32'h77, 2'd3, 4'b1111);
        chk("t5_ffff", {16'b0, xfer_cnt}, 32'hFFFF);
        step(1'b1, 1'b1, 32'h78, 2'd0, 4'b1111);
        chk("t5_wrap", {16'b0, xfer_cnt}, 32'h0000);

        // T6 reset while all channels are full and stalled
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 32'hF0 + 32'(k), 2'(k), 4'b0000);
        end
        chk("t6_full", {28'b0, ou_valid}, 32'b1111);
        step(1'b0, 1'b1, 32'h99, 2'd0, 4'b0000);
        chk("t6_valid", {28'b0, ou_valid}, 32'd0);
        chk("t6_cnt", {16'b0, xfer_cnt}, 32'd0);
        chk("t6_ou1", ou1, 32'd0);
        step(1'b1, 1'b0, 32'h0, 2'd0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
